// File: rtl/fifo_drain_arbiter_if.sv
// Read-side bundle between the drain arbiter, its source FIFOs and the downstream
// consumer: per-FIFO empty/data/pop lines plus the merged valid/ready output stream.
interface fifo_drain_arbiter_if #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = 2
);
  logic [NUM_Q-1:0]            fifo_rempty;
  logic [NUM_Q*DATA_WIDTH-1:0] fifo_rdata;
  logic [NUM_Q-1:0]            fifo_rinc;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]            out_src;

  modport master (
    input  fifo_rempty, fifo_rdata, out_ready,
    output fifo_rinc, out_valid, out_data, out_src
  );

  modport slave (
    output fifo_rempty, fifo_rdata, out_ready,
    input  fifo_rinc, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_Q read-side FIFO ports into one valid/ready stream,
// up to BURST_LEN pops per grant, with a 2-entry output queue and credit-based popping.
//
// state | meaning
// IDLE  | no grant held; searches for the next non-empty FIFO after last_grant
// BURST | grant held; pops the granted FIFO while it has data, credit and en
module fifo_drain_arbiter #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 en,
  output logic                 busy,
  fifo_drain_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  grant, grant_d;
  logic [SEL_W-1:0]  last_grant, last_grant_d;
  logic [CNT_W-1:0]  count, count_d;
  logic              pop;
  logic [NUM_Q-1:0]  rinc;

  logic              search_found;
  logic [SEL_W-1:0]  search_idx;
  int                idx;

  logic              inflight;
  logic [SEL_W-1:0]  inflight_src;

  logic [DATA_WIDTH-1:0] q_data [2];
  logic [SEL_W-1:0]      q_src  [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            q_count;
  logic                  deq;
  logic [1:0]            occupancy;
  logic                  credit;

  // Words already committed downstream: queued plus in flight, minus the one leaving now.
  assign deq       = (q_count != 2'd0) && bus.out_ready;
  assign occupancy = q_count + {1'b0, inflight} - {1'b0, deq};
  assign credit    = occupancy < 2'd2;

  always_comb begin
    search_found = 1'b0;
    search_idx   = last_grant;
    idx          = 0;
    for (int i = 1; i <= NUM_Q; i++) begin
      idx = (int'(last_grant) + i) % NUM_Q;
      if (!search_found && !bus.fifo_rempty[idx]) begin
        search_found = 1'b1;
        search_idx   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    count_d      = count;
    pop          = 1'b0;
    rinc         = '0;
    case (state)
      IDLE: begin
        if (en && search_found) begin
          grant_d = search_idx;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        pop = !bus.fifo_rempty[grant] && credit && en;
        if (pop) begin
          count_d = count + 1'b1;
        end
        // A credit stall alone holds the grant; anything else ends the burst.
        if ((pop && (count_d == CNT_W'(BURST_LEN))) || bus.fifo_rempty[grant] || !en) begin
          state_d      = IDLE;
          last_grant_d = grant;
        end
        rinc[grant] = pop;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(NUM_Q - 1);
      count      <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      count      <= count_d;
    end
  end

  // Block-RAM read data arrives one cycle after the pop; push it straight into the queue.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight     <= 1'b0;
      inflight_src <= '0;
      q_data[0]    <= '0;
      q_data[1]    <= '0;
      q_src[0]     <= '0;
      q_src[1]     <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      q_count      <= 2'd0;
    end else begin
      inflight <= pop;
      if (pop) begin
        inflight_src <= grant;
      end
      if (inflight) begin
        q_data[wr_ptr] <= bus.fifo_rdata[inflight_src*DATA_WIDTH +: DATA_WIDTH];
        q_src[wr_ptr]  <= inflight_src;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      q_count <= q_count + {1'b0, inflight} - {1'b0, deq};
    end
  end

  assign bus.fifo_rinc = rinc;
  assign bus.out_valid = q_count != 2'd0;
  assign bus.out_data  = q_data[rd_ptr];
  assign bus.out_src   = q_src[rd_ptr];
  assign busy          = (state == BURST) || inflight || (q_count != 2'd0);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench: FIFO contents are modelled as queues, expected output order comes from
// a round-robin burst planner over those contents, and every cycle is checked against it.
module tb_fifo_drain_arbiter;
  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int SW = 2;

  logic clk;
  logic arst_n;
  logic en;
  logic busy;

  fifo_drain_arbiter_if #(.NUM_Q(NQ), .DATA_WIDTH(DW), .SEL_W(SW)) bus ();

  fifo_drain_arbiter #(.NUM_Q(NQ), .DATA_WIDTH(DW), .BURST_LEN(BL), .SEL_W(SW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (en),
    .busy   (busy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;
  logic [DW-1:0]    fq [NQ][$];
  int               seq [NQ];
  logic [SW+DW-1:0] sb [$];
  int               m_last;

  int               cyc, pop_cnt, hs_cnt, last_pop_cyc, gap1, gap2;
  int               qpops [NQ];
  logic [NQ-1:0]    first_rinc;
  bit               first_seen;
  bit               prev_stall;
  logic [SW+DW-1:0] prev_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic test_begin();
    pop_cnt = 0; hs_cnt = 0; last_pop_cyc = -1; gap1 = 0; gap2 = 0;
    first_rinc = '0; first_seen = 0;
    for (int i = 0; i < NQ; i++) qpops[i] = 0;
  endtask

  task automatic load(input int q, input int n);
    for (int k = 0; k < n; k++) begin
      fq[q].push_back({8'(q), 24'(seq[q])});
      seq[q]++;
    end
    bus.fifo_rempty[q] = (fq[q].size() == 0);
  endtask

  // Round-robin over the current FIFO contents: next non-empty after the last grantee,
  // take up to BL words, rotate.
  task automatic plan();
    int left [NQ];
    int pos  [NQ];
    int g, n;
    for (int i = 0; i < NQ; i++) begin left[i] = fq[i].size(); pos[i] = 0; end
    g = 0;
    while (g >= 0) begin
      g = -1;
      for (int k = 1; k <= NQ; k++) begin
        int c;
        c = (m_last + k) % NQ;
        if (g < 0 && left[c] > 0) g = c;
      end
      if (g >= 0) begin
        n = (left[g] < BL) ? left[g] : BL;
        for (int k = 0; k < n; k++) sb.push_back({SW'(g), fq[g][pos[g] + k]});
        pos[g] += n;
        left[g] -= n;
        m_last = g;
      end
    end
  endtask

  task automatic step();
    logic [NQ-1:0] r;
    logic [SW+DW-1:0] w, cur;
    @(negedge clk);
    cyc++;
    r   = bus.fifo_rinc;
    cur = {bus.out_src, bus.out_data};
    chk("rinc_onehot0", 64'($onehot0(r)), 64'd1);
    chk("rinc_on_empty", 64'(r & bus.fifo_rempty), 64'd0);
    if (prev_stall) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_word", 64'(cur), 64'(prev_word));
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL out_word: got %0h expected no word (cycle %0d)", cur, cyc);
      end else begin
        w = sb.pop_front();
        chk("out_word", 64'(cur), 64'(w));
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_word  = cur;
    if (r != '0) begin
      pop_cnt++;
      for (int i = 0; i < NQ; i++) if (r[i]) qpops[i]++;
      if (!first_seen) begin first_rinc = r; first_seen = 1; end
      if (last_pop_cyc >= 0) begin
        if (cyc - last_pop_cyc == 1) gap1++;
        else if (cyc - last_pop_cyc == 2) gap2++;
      end
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (r[i]) begin
        bus.fifo_rdata[i*DW +: DW] = (fq[i].size() > 0) ? fq[i].pop_front() : 32'hDEAD_DEAD;
        bus.fifo_rempty[i] = (fq[i].size() == 0);
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin step(); k++; end
    total++;
    if (sb.size() != 0 || busy) begin
      bad++;
      $display("FAIL %s_drain: got %0d words left busy=%0b expected 0 words busy=0", name, sb.size(), busy);
    end
  endtask

  initial begin
    int k, p0;
    total = 0; bad = 0; cyc = 0; m_last = NQ - 1; prev_stall = 0; prev_word = '0;
    for (int i = 0; i < NQ; i++) seq[i] = 0;
    arst_n = 1'b0; en = 1'b0;
    bus.out_ready   = 1'b1;
    bus.fifo_rempty = '1;
    bus.fifo_rdata  = '0;
    test_begin();

    // Reset values
    step(); step();
    chk("rst_rinc", 64'(bus.fifo_rinc), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_src", 64'(bus.out_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    arst_n = 1'b1;
    step();

    // Reset asserted mid-burst from Q1: outputs clear without waiting for a clock
    test_begin();
    load(1, 6); load(2, 2); plan();
    en = 1'b1;
    k = 0;
    while (pop_cnt < 3 && k < 20) begin step(); k++; end
    chk("t1_pops_before_rst", 64'(pop_cnt), 64'd3);
    arst_n = 1'b0;
    #1;
    chk("t1_rinc", 64'(bus.fifo_rinc), 64'd0);
    chk("t1_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_data", 64'(bus.out_data), 64'd0);
    chk("t1_src", 64'(bus.out_src), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    prev_stall = 0;
    en = 1'b0;
    sb.delete();
    for (int i = 0; i < NQ; i++) fq[i].delete();
    bus.fifo_rempty = '1;
    m_last = NQ - 1;
    step(); step();
    arst_n = 1'b1;
    step();

    // All four FIFOs hold 3 words: Q0x3, Q1x3, Q2x3, Q3x3; first grant after reset is Q0
    test_begin();
    for (int q = 0; q < NQ; q++) load(q, 3);
    plan();
    en = 1'b1;
    drain("t3", 100);
    chk("t3_first_rinc", 64'(first_rinc), 64'h1);
    chk("t3_pops", 64'(pop_cnt), 64'd12);

    // Q0 alone with 20 words: bursts 8,8,4 with one dead cycle between bursts
    test_begin();
    en = 1'b0;
    load(0, 20); plan();
    en = 1'b1;
    drain("t2", 200);
    chk("t2_pops", 64'(pop_cnt), 64'd20);
    chk("t2_b2b_gaps", 64'(gap1), 64'd17);
    chk("t2_switch_gaps", 64'(gap2), 64'd2);

    // Q1 with 10 words, consumer stalls 5 cycles after the third accepted word
    test_begin();
    en = 1'b0;
    load(1, 10); plan();
    en = 1'b1;
    k = 0;
    while (hs_cnt < 3 && k < 40) begin step(); k++; end
    chk("t4_hs_before_stall", 64'(hs_cnt), 64'd3);
    bus.out_ready = 1'b0;
    p0 = pop_cnt;
    repeat (5) step();
    chk("t4_stall_pops", 64'(pop_cnt - p0), 64'd0);
    chk("t4_queued", 64'(pop_cnt - hs_cnt), 64'd2);
    bus.out_ready = 1'b1;
    drain("t4", 100);
    chk("t4_pops", 64'(pop_cnt), 64'd10);

    // en falls once Q3 has been popped 4 times; the in-flight 4th word still comes out
    test_begin();
    en = 1'b0;
    load(3, 6); load(0, 3);
    for (int j = 0; j < 4; j++) sb.push_back({SW'(3), fq[3][j]});
    m_last = 3;
    en = 1'b1;
    k = 0;
    while (pop_cnt < 4 && k < 40) begin step(); k++; end
    en = 1'b0;
    drain("t5a", 40);
    repeat (3) step();
    chk("t5_pops", 64'(pop_cnt), 64'd4);
    chk("t5_q3_pops", 64'(qpops[3]), 64'd4);
    chk("t5_busy", 64'(busy), 64'd0);
    test_begin();
    plan();
    en = 1'b1;
    drain("t5b", 100);
    chk("t5_regrant", 64'(first_rinc), 64'h1);
    chk("t5_rest_pops", 64'(pop_cnt), 64'd5);

    // Q2 runs dry after 2 pops, grant rotates to Q3
    test_begin();
    en = 1'b0;
    load(2, 2); load(3, 3); plan();
    en = 1'b1;
    drain("t6", 100);
    chk("t6_first_rinc", 64'(first_rinc), 64'h4);
    chk("t6_q2_pops", 64'(qpops[2]), 64'd2);
    chk("t6_q3_pops", 64'(qpops[3]), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit reached expected finish");
    $fatal(1);
  end

endmodule
